// File: rtl/murmur_word_feeder.sv
// ============================================================================
// Module   : murmur_word_feeder
// Brief    : Splits a text byte stream into delimiter-separated words. Packs
//            each word (lowercased, zero padded) into a 256-bit word. Drives
//            the hasher for an exact enable window and reports one result
//            per word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module murmur_word_feeder #(
  parameter int         MAX_BYTES   = 32,
  parameter logic [7:0] DELIM       = 8'h20,
  parameter int         HASH_CYCLES = 9
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  input  logic         byte_last,
  output logic         byte_ready,
  output logic         hash_enable,
  output logic [255:0] hash_word,
  input  logic         hash_ready,
  input  logic         hash_is_present,
  output logic         result_valid,
  output logic         result_present,
  output logic [5:0]   result_length,
  output logic         result_overflow,
  output logic         hash_error
);

  localparam int                CYC_W    = $clog2(HASH_CYCLES + 1);
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(HASH_CYCLES - 1);
  localparam logic [5:0]        CNT_FULL = 6'(MAX_BYTES);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HASH    = 2'd1,
    RESULT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [255:0]     word_q, word_d;
  logic [5:0]       count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             hash_enable_q, hash_enable_d;
  logic             result_valid_q, result_valid_d;
  logic             result_present_q, result_present_d;
  logic [5:0]       result_length_q, result_length_d;
  logic             result_overflow_q, result_overflow_d;
  logic             hash_error_q, hash_error_d;
  logic [7:0]       folded;

  // Case fold: map A-Z to a-z so that both spellings hash identically.
  always_comb begin
    folded = byte_data;
    if (byte_data >= 8'h41 && byte_data <= 8'h5A) begin
      folded = byte_data | 8'h20;
    end
  end

  // Next-state logic for the word buffer, hash window and result registers.
  always_comb begin
    state_d           = state_q;
    word_d            = word_q;
    count_d           = count_q;
    ovf_d             = ovf_q;
    cyc_d             = cyc_q;
    hash_enable_d     = hash_enable_q;
    result_valid_d    = 1'b0;
    result_present_d  = result_present_q;
    result_length_d   = result_length_q;
    result_overflow_d = result_overflow_q;
    hash_error_d      = 1'b0;

    case (state_q)
      COLLECT: begin
        if (byte_valid) begin
          if (byte_data == DELIM) begin
            // Delimiters with an empty buffer are ignored, so runs of
            // delimiters produce no words.
            if (count_q != 6'd0) begin
              state_d       = HASH;
              hash_enable_d = 1'b1;
              cyc_d         = '0;
            end
          end else begin
            if (count_q < CNT_FULL) begin
              word_d[{count_q[4:0], 3'b000} +: 8] = folded;
              count_d = count_q + 6'd1;
            end else begin
              ovf_d = 1'b1;
            end
            // End of stream closes the word without needing a delimiter.
            if (byte_last && count_d != 6'd0) begin
              state_d       = HASH;
              hash_enable_d = 1'b1;
              cyc_d         = '0;
            end
          end
        end
      end

      HASH: begin
        // The hasher wraps its round index only on an exact window, so the
        // enable must cover exactly HASH_CYCLES edges.
        if (hash_enable_q) begin
          cyc_d = cyc_q + 1'b1;
          if (cyc_q == CYC_LAST) begin
            hash_enable_d = 1'b0;
            state_d       = RESULT;
          end
        end
      end

      RESULT: begin
        result_valid_d    = 1'b1;
        result_present_d  = hash_is_present;
        result_length_d   = count_q;
        result_overflow_d = ovf_q;
        hash_error_d      = !hash_ready;
        word_d            = '0;
        count_d           = 6'd0;
        ovf_d             = 1'b0;
        state_d           = COLLECT;
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q           <= COLLECT;
      word_q            <= '0;
      count_q           <= 6'd0;
      ovf_q             <= 1'b0;
      cyc_q             <= '0;
      hash_enable_q     <= 1'b0;
      result_valid_q    <= 1'b0;
      result_present_q  <= 1'b0;
      result_length_q   <= 6'd0;
      result_overflow_q <= 1'b0;
      hash_error_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      word_q            <= word_d;
      count_q           <= count_d;
      ovf_q             <= ovf_d;
      cyc_q             <= cyc_d;
      hash_enable_q     <= hash_enable_d;
      result_valid_q    <= result_valid_d;
      result_present_q  <= result_present_d;
      result_length_q   <= result_length_d;
      result_overflow_q <= result_overflow_d;
      hash_error_q      <= hash_error_d;
    end
  end

  assign byte_ready      = (state_q == COLLECT);
  assign hash_enable     = hash_enable_q;
  assign hash_word       = word_q;
  assign result_valid    = result_valid_q;
  assign result_present  = result_present_q;
  assign result_length   = result_length_q;
  assign result_overflow = result_overflow_q;
  assign hash_error      = hash_error_q;

endmodule

`default_nettype wire

// File: tb/tb_murmur_word_feeder.sv
// ============================================================================
// Module   : tb_murmur_word_feeder
// Brief    : Directed self-checking bench for murmur_word_feeder. It uses a
//            small behavioural hasher that remembers the words it has seen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_murmur_word_feeder;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         byte_valid = 1'b0;
  logic [7:0]   byte_data = 8'h00;
  logic         byte_last = 1'b0;
  logic         byte_ready;
  logic         hash_enable;
  logic [255:0] hash_word;
  logic         hash_ready = 1'b1;
  logic         hash_is_present;
  logic         result_valid;
  logic         result_present;
  logic [5:0]   result_length;
  logic         result_overflow;
  logic         hash_error;

  murmur_word_feeder dut (
    .clock           (clock),
    .reset           (reset),
    .byte_valid      (byte_valid),
    .byte_data       (byte_data),
    .byte_last       (byte_last),
    .byte_ready      (byte_ready),
    .hash_enable     (hash_enable),
    .hash_word       (hash_word),
    .hash_ready      (hash_ready),
    .hash_is_present (hash_is_present),
    .result_valid    (result_valid),
    .result_present  (result_present),
    .result_length   (result_length),
    .result_overflow (result_overflow),
    .hash_error      (hash_error)
  );

  always #5 clock = ~clock;

  // Free-running cycle counter used for latency measurement.
  logic [31:0] cyc = 32'd0;
  always @(posedge clock) cyc <= cyc + 32'd1;

  // Behavioural hasher: counts enabled edges and on the 9th registers
  // whether the word was seen before, then remembers it.
  logic [255:0] seen_mem [16];
  int           seen_n = 0;
  int           hcnt = 0;
  logic         model_clr = 1'b0;
  logic         pres_r = 1'b0;
  assign hash_is_present = pres_r;

  function automatic logic was_seen(input logic [255:0] w);
    for (int i = 0; i < 16; i++) begin
      if (i < seen_n && seen_mem[i] == w) return 1'b1;
    end
    return 1'b0;
  endfunction

  // The model's round counter is reinitialised with the system reset.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      hcnt <= 0;
    end else if (model_clr) begin
      seen_n <= 0;
    end else if (hash_enable) begin
      if (hcnt == 8) begin
        hcnt   <= 0;
        pres_r <= was_seen(hash_word);
        if (seen_n < 16) begin
          seen_mem[seen_n] <= hash_word;
          seen_n           <= seen_n + 1;
        end
      end else begin
        hcnt <= hcnt + 1;
      end
    end
  end

  // Monitor: records enable windows, word snapshots and results.
  typedef struct packed {
    logic [5:0]  len;
    logic        pres;
    logic        ovf;
    logic        err;
    logic [31:0] at;
  } res_t;

  res_t         res_q[$];
  int           en_q[$];
  logic [255:0] snap_q[$];
  int           en_run = 0;
  logic         en_prev = 1'b0;

  always @(negedge clock) begin
    if (hash_enable) begin
      if (!en_prev) snap_q.push_back(hash_word);
      en_run <= en_run + 1;
    end else if (en_prev) begin
      en_q.push_back(en_run);
      en_run <= 0;
    end
    en_prev <= hash_enable;
    if (result_valid) begin
      res_q.push_back({result_length, result_present, result_overflow,
                       hash_error, cyc});
    end
  end

  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] t_last  = 32'd0;

  task automatic check_val(input string tag, input logic [255:0] got,
                           input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int k;
    k = 0;
    @(negedge clock);
    while (!byte_ready && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (!byte_ready) check_val("ready_timeout", 256'(byte_ready), 256'd1);
    byte_valid = 1'b1;
    byte_data  = d;
    byte_last  = last;
    @(posedge clock);
    #1;
    t_last     = cyc;
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input logic last_on_final);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], last_on_final && (i == s.len() - 1));
    end
  endtask

  task automatic wait_results(input int n);
    int k;
    k = 0;
    while (res_q.size() < n && k < 200) begin
      @(posedge clock);
      k++;
    end
    check_val("result_count", 256'(res_q.size()), 256'(n));
  endtask

  int           rb, eb, sb;
  logic [255:0] exp_w;
  logic [7:0]   xs;

  initial begin
    // Reset state.
    repeat (3) @(negedge clock);
    check_val("rst_byte_ready", 256'(byte_ready), 256'd1);
    check_val("rst_hash_enable", 256'(hash_enable), 256'd0);
    check_val("rst_hash_word", hash_word, 256'd0);
    check_val("rst_result_valid", 256'(result_valid), 256'd0);
    check_val("rst_result_length", 256'(result_length), 256'd0);
    check_val("rst_hash_error", 256'(hash_error), 256'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // "cat ": packing, window length and latency.
    rb = res_q.size(); eb = en_q.size(); sb = snap_q.size();
    send_str("cat ", 1'b0);
    wait_results(rb + 1);
    check_val("cat_word_low", 256'(snap_q[sb][31:0]), 256'h00746163);
    check_val("cat_word_full", snap_q[sb], 256'h00746163);
    check_val("cat_en_cycles", 256'(en_q[eb]), 256'd9);
    check_val("cat_latency", 256'(res_q[rb].at - t_last), 256'd10);
    check_val("cat_length", 256'(res_q[rb].len), 256'd3);
    check_val("cat_present", 256'(res_q[rb].pres), 256'd0);
    check_val("cat_error", 256'(res_q[rb].err), 256'd0);

    // "cat CAT " with a fresh filter: case folding makes the second a hit.
    @(negedge clock); model_clr = 1'b1;
    @(negedge clock); model_clr = 1'b0;
    rb = res_q.size(); sb = snap_q.size();
    send_str("cat CAT ", 1'b0);
    wait_results(rb + 2);
    check_val("cc_first_present", 256'(res_q[rb].pres), 256'd0);
    check_val("cc_second_present", 256'(res_q[rb + 1].pres), 256'd1);
    check_val("cc_second_word", snap_q[sb + 1], 256'h00746163);
    check_val("cc_second_length", 256'(res_q[rb + 1].len), 256'd3);

    // "  a  b ": delimiter runs produce no extra words.
    rb = res_q.size();
    send_str("  a  b ", 1'b0);
    wait_results(rb + 2);
    repeat (15) @(posedge clock);
    check_val("ab_count", 256'(res_q.size() - rb), 256'd2);
    check_val("ab_len_a", 256'(res_q[rb].len), 256'd1);
    check_val("ab_len_b", 256'(res_q[rb + 1].len), 256'd1);

    // 40 'x' then space: truncation to 32 bytes with overflow flag.
    rb = res_q.size(); sb = snap_q.size();
    for (int i = 0; i < 40; i++) send_byte(8'h78, 1'b0);
    send_byte(8'h20, 1'b0);
    wait_results(rb + 1);
    xs = 8'h78;
    exp_w = {32{xs}};
    check_val("ovf_length", 256'(res_q[rb].len), 256'd32);
    check_val("ovf_flag", 256'(res_q[rb].ovf), 256'd1);
    check_val("ovf_word", snap_q[sb], exp_w);

    // "dog" terminated by byte_last.
    rb = res_q.size(); sb = snap_q.size();
    send_str("dog", 1'b1);
    wait_results(rb + 1);
    check_val("dog_length", 256'(res_q[rb].len), 256'd3);
    check_val("dog_word", snap_q[sb], 256'h00676f64);
    check_val("dog_latency", 256'(res_q[rb].at - t_last), 256'd10);

    // Reset during the 4th HASH cycle.
    rb = res_q.size();
    send_str("hi ", 1'b0);
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check_val("mid_rst_enable", 256'(hash_enable), 256'd0);
    check_val("mid_rst_ready", 256'(byte_ready), 256'd1);
    check_val("mid_rst_word", hash_word, 256'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (15) @(posedge clock);
    check_val("mid_rst_no_result", 256'(res_q.size()), 256'(rb));
    eb = en_q.size();
    send_str("ok ", 1'b0);
    wait_results(rb + 1);
    check_val("after_rst_en_cycles", 256'(en_q[eb]), 256'd9);
    check_val("after_rst_length", 256'(res_q[rb].len), 256'd2);

    // hash_ready low in the RESULT cycle flags a per-word error.
    rb = res_q.size();
    send_str("yes ", 1'b0);
    repeat (9) @(posedge clock);
    #1 hash_ready = 1'b0;
    @(posedge clock);
    #1 hash_ready = 1'b1;
    wait_results(rb + 1);
    check_val("err_flag", 256'(res_q[rb].err), 256'd1);
    check_val("err_length", 256'(res_q[rb].len), 256'd3);
    send_str("no ", 1'b0);
    wait_results(rb + 2);
    check_val("err_not_sticky", 256'(res_q[rb + 1].err), 256'd0);

    repeat (5) @(posedge clock);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
